case_select_decoder: RTL and testbench

- Inverse of the 2-bit inc/pass/dec operation unit.
- Observes (number, result) pairs from that unit through a valid/ready handshake and recovers the select code that produced each pair: 00 inc, 01 pass, 10 dec, 11 no match.
- Registers the decoded code in a one-entry output stage with backpressure.
- Keeps saturating per-code statistics and a sticky mismatch flag for the datapath checker.

---
 rtl/case_select_decoder.sv | 124 ++++++++++++
 tb/tb_case_select_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/case_select_decoder.sv
// Recovers the inc/pass/dec select code from observed (number, result) pairs,
// holds it in a one-entry output stage and keeps saturating per-code statistics.
module case_select_decoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     number,
    input  logic [WIDTH-1:0]     result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           select,
    output logic [WIDTH-1:0]     out_number,
    input  logic                 clr_counts,
    output logic [CNT_WIDTH-1:0] inc_count,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] dec_count,
    output logic [CNT_WIDTH-1:0] bad_count,
    output logic                 err_sticky
);

    localparam logic [1:0] CODE_INC  = 2'b00;
    localparam logic [1:0] CODE_PASS = 2'b01;
    localparam logic [1:0] CODE_DEC  = 2'b10;
    localparam logic [1:0] CODE_BAD  = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic [1:0] code;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
    endfunction

    // Decode the presented pair; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        code = CODE_BAD;
        if (result == WIDTH'(number + WIDTH'(1))) begin
            code = CODE_INC;
        end else if (result == number) begin
            code = CODE_PASS;
        end else if (result == WIDTH'(number - WIDTH'(1))) begin
            code = CODE_DEC;
        end
    end

    // Output stage next-state and handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        accept     = 1'b0;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                in_ready = out_ready;
                accept   = in_valid & out_ready;
                if (out_ready && !accept) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            select     <= CODE_INC;
            out_number <= '0;
        end else if (accept) begin
            select     <= code;
            out_number <= number;
        end
    end

    // Clear wins over a same-cycle accept; the pair is still forwarded above.
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            inc_count  <= '0;
            pass_count <= '0;
            dec_count  <= '0;
            bad_count  <= '0;
            err_sticky <= 1'b0;
        end else if (accept) begin
            case (code)
                CODE_INC:  inc_count  <= sat_inc(inc_count);
                CODE_PASS: pass_count <= sat_inc(pass_count);
                CODE_DEC:  dec_count  <= sat_inc(dec_count);
                default: begin
                    bad_count  <= sat_inc(bad_count);
                    err_sticky <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_select_decoder.sv
// Directed and randomized checks of case_select_decoder against a pair-level
// reference model (decode by wrapped difference, saturating integer counters).
module tb_case_select_decoder;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned CNT_WIDTH = 4;
    localparam int          CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     number;
    logic [WIDTH-1:0]     result;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           select;
    logic [WIDTH-1:0]     out_number;
    logic                 clr_counts;
    logic [CNT_WIDTH-1:0] inc_count;
    logic [CNT_WIDTH-1:0] pass_count;
    logic [CNT_WIDTH-1:0] dec_count;
    logic [CNT_WIDTH-1:0] bad_count;
    logic                 err_sticky;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_valid;
    int       m_sel;
    int       m_num;
    int       m_cnt[4];
    bit       m_sticky;

    case_select_decoder #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .number     (number),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .select     (select),
        .out_number (out_number),
        .clr_counts (clr_counts),
        .inc_count  (inc_count),
        .pass_count (pass_count),
        .dec_count  (dec_count),
        .bad_count  (bad_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic int ref_code(input int n, input int r);
        int diff;
        diff = (r - n) & ((1 << WIDTH) - 1);
        if (diff == 1) return 0;
        if (diff == 0) return 1;
        if (diff == (1 << WIDTH) - 1) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(out_valid),  32'(m_valid));
        chk("select",     32'(select),     32'(m_sel));
        chk("out_number", 32'(out_number), 32'(m_num));
        chk("inc_count",  32'(inc_count),  32'(m_cnt[0]));
        chk("pass_count", 32'(pass_count), 32'(m_cnt[1]));
        chk("dec_count",  32'(dec_count),  32'(m_cnt[2]));
        chk("bad_count",  32'(bad_count),  32'(m_cnt[3]));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    // One clock: drive, check in_ready before the edge, advance model, check after.
    task automatic step(input logic iv, input int n, input int r, input logic ordy,
                        input logic clr, input logic rs, input bit chk_ready);
        bit ir;
        bit acc;
        int code;
        in_valid   = iv;
        number     = WIDTH'(n);
        result     = WIDTH'(r);
        out_ready  = ordy;
        clr_counts = clr;
        rst        = rs;
        #1;
        ir = !m_valid || ordy;
        if (chk_ready) chk("in_ready", 32'(in_ready), 32'(ir));
        @(posedge clk);
        if (rs) begin
            m_valid  = 0;
            m_sel    = 0;
            m_num    = 0;
            m_sticky = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            acc  = iv && ir;
            code = ref_code(n & 'hFF, r & 'hFF);
            if (acc) begin
                m_valid = 1;
                m_sel   = code;
                m_num   = n & 'hFF;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (clr) begin
                m_sticky = 0;
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (acc) begin
                if (m_cnt[code] < CNT_MAX) m_cnt[code]++;
                if (code == 3) m_sticky = 1;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        int n;
        int r;
        int kind;
        in_valid = 0; number = '0; result = '0; out_ready = 1;
        clr_counts = 0; rst = 1;

        // Reset
        step(0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 1);

        // Basic decode, then back-to-back pass/dec/bad
        step(1, 'h10, 'h11, 1, 0, 0, 1);
        step(1, 'h10, 'h10, 1, 0, 0, 1);
        step(1, 'h10, 'h0F, 1, 0, 0, 1);
        step(1, 'h10, 'h55, 1, 0, 0, 1);

        // Wrap-around
        step(1, 'hFF, 'h00, 1, 0, 0, 1);
        step(1, 'h00, 'hFF, 1, 0, 0, 1);
        step(1, 'h00, 'h00, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);

        // Backpressure with a pending pair
        step(1, 'h20, 'h21, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 'h30, 'h2F, 0, 0, 0, 1);
        step(1, 'h30, 'h2F, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);

        // Clear coincident with a bad pair
        step(1, 'h40, 'h99, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Saturation of inc_count
        for (int i = 0; i < CNT_MAX + 2; i++) step(1, i, i + 1, 1, 0, 0, 1);

        // Reset while FULL
        step(1, 'h55, 'h56, 0, 0, 0, 1);
        step(1, 'h66, 'h67, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            n    = int'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: r = n + 1;
                1: r = n;
                2: r = n - 1;
                default: r = int'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, n, r, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
